l2c_normal_loop_ctrl: RTL and testbench

- Parametrised L2 controller for the normal (steady-state) convolution phase.
- Iterates over a configured number of output rows. Each row, it issues one per-channel pop/push request set to the L3 FIFO controllers, then waits until every enabled channel reports completion.
- Adds a channel-enable mask, layer-type-dependent FIFO usage, sticky done tracking, abort and an illegal-config flag.
- Sits between the token-engine top FSM (after preheat) and the L3 ifmap/ipsum/opsum FIFO controllers.

---
 rtl/l2c_normal_loop_ctrl_if.sv | 49 ++++
 rtl/l2c_normal_loop_ctrl.sv | 173 +++++++++++++++++
 tb/tb_l2c_normal_loop_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2c_normal_loop_ctrl_if.sv
// Signal bundle for the L2 normal-loop controller: it carries the run command and
// configuration from the token-engine top FSM, and the per-channel request and done
// lines that go to and from the L3 ifmap/ipsum/opsum FIFO controllers.
interface l2c_normal_loop_ctrl_if #(
    parameter int NUM_CH = 32,
    parameter int CNT_W  = 16,
    parameter int ROW_W  = 16
) ();
    logic                    start_i;
    logic                    abort_i;
    logic [1:0]              layer_type_i;
    logic [ROW_W-1:0]        num_rows_i;
    logic [CNT_W-1:0]        ifmap_pop_cfg_i;
    logic [CNT_W-1:0]        ipsum_pop_cfg_i;
    logic [NUM_CH-1:0]       ch_en_i;
    logic [NUM_CH-1:0]       ifmap_done_i;
    logic [NUM_CH-1:0]       ipsum_done_i;
    logic [NUM_CH-1:0]       opsum_done_i;

    logic [NUM_CH-1:0]       ifmap_need_pop_o;
    logic [NUM_CH*CNT_W-1:0] ifmap_pop_num_o;
    logic [NUM_CH-1:0]       ipsum_need_pop_o;
    logic [NUM_CH*CNT_W-1:0] ipsum_pop_num_o;
    logic [NUM_CH-1:0]       opsum_need_push_o;
    logic [ROW_W-1:0]        row_idx_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    // The side that commands the controller and returns FIFO completions.
    modport master (
        output start_i, abort_i, layer_type_i, num_rows_i,
               ifmap_pop_cfg_i, ipsum_pop_cfg_i, ch_en_i,
               ifmap_done_i, ipsum_done_i, opsum_done_i,
        input  ifmap_need_pop_o, ifmap_pop_num_o, ipsum_need_pop_o,
               ipsum_pop_num_o, opsum_need_push_o, row_idx_o,
               busy_o, done_o, err_o
    );

    // The controller itself.
    modport slave (
        input  start_i, abort_i, layer_type_i, num_rows_i,
               ifmap_pop_cfg_i, ipsum_pop_cfg_i, ch_en_i,
               ifmap_done_i, ipsum_done_i, opsum_done_i,
        output ifmap_need_pop_o, ifmap_pop_num_o, ipsum_need_pop_o,
               ipsum_pop_num_o, opsum_need_push_o, row_idx_o,
               busy_o, done_o, err_o
    );
endinterface

// File: rtl/l2c_normal_loop_ctrl.sv
// L2 controller for the steady-state convolution phase. For each output row it
// issues one request set to the L3 FIFO controllers (a single SET_NUM cycle), then
// waits until every requested channel of every FIFO type has reported done.
module l2c_normal_loop_ctrl #(
    parameter int NUM_CH = 32,
    parameter int CNT_W  = 16,
    parameter int ROW_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2c_normal_loop_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_NUM,
        S_WAIT_DONE,
        S_NEXT_ROW,
        S_DONE
    } state_t;

    localparam logic [1:0] LT_DEPTHWISE = 2'd1;
    localparam logic [1:0] LT_ILLEGAL   = 2'd3;

    state_t            state;
    state_t            state_nxt;

    // Configuration latched on an accepted start.
    logic [1:0]        layer_type_q;
    logic [ROW_W-1:0]  num_rows_q;
    logic [CNT_W-1:0]  ifmap_cfg_q;
    logic [CNT_W-1:0]  ipsum_cfg_q;
    logic [NUM_CH-1:0] ch_en_q;

    logic [ROW_W-1:0]  row_idx_q;
    logic [NUM_CH-1:0] ifmap_sticky_q;
    logic [NUM_CH-1:0] ipsum_sticky_q;
    logic [NUM_CH-1:0] opsum_sticky_q;
    logic              err_q;
    logic              done_q;

    logic              start_accept;
    logic              abort_hit;
    logic              last_row;
    logic              row_complete;
    logic              set_num;
    logic [NUM_CH-1:0] ifmap_mask;
    logic [NUM_CH-1:0] ipsum_mask;
    logic [NUM_CH-1:0] opsum_mask;

    // Per-type request masks for the current row; depthwise layers never touch ipsum.
    assign ifmap_mask = ch_en_q;
    assign opsum_mask = ch_en_q;
    assign ipsum_mask = (layer_type_q == LT_DEPTHWISE) ? '0 : ch_en_q;

    assign set_num   = (state == S_SET_NUM);
    assign abort_hit = bus.abort_i && (state != S_IDLE);
    assign last_row  = (row_idx_q == (num_rows_q - ROW_W'(1)));

    // A channel is satisfied if it already reported, reports now, or was never asked.
    assign row_complete = (&(ifmap_sticky_q | bus.ifmap_done_i | ~ifmap_mask)) &&
                          (&(ipsum_sticky_q | bus.ipsum_done_i | ~ipsum_mask)) &&
                          (&(opsum_sticky_q | bus.opsum_done_i | ~opsum_mask));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values; a
        // blocking assignment here would make results depend on evaluation order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        // NOTE: defaults come first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        state_nxt    = state;
        start_accept = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    start_accept = 1'b1;
                    if (bus.layer_type_i == LT_ILLEGAL || bus.num_rows_i == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_SET_NUM;
                end
            end
            S_SET_NUM:   state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (row_complete) state_nxt = S_NEXT_ROW;
            S_NEXT_ROW:  state_nxt = last_row ? S_DONE : S_SET_NUM;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    // Capture the run configuration on an accepted start; inputs are ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_type_q <= '0;
            num_rows_q   <= '0;
            ifmap_cfg_q  <= '0;
            ipsum_cfg_q  <= '0;
            ch_en_q      <= '0;
        end else if (start_accept) begin
            layer_type_q <= bus.layer_type_i;
            num_rows_q   <= bus.num_rows_i;
            ifmap_cfg_q  <= bus.ifmap_pop_cfg_i;
            ipsum_cfg_q  <= bus.ipsum_pop_cfg_i;
            ch_en_q      <= bus.ch_en_i;
        end
    end

    // Row index: zeroed on start or abort, advanced when another row follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            row_idx_q <= '0;
        else if (abort_hit || start_accept)    row_idx_q <= '0;
        else if (state == S_NEXT_ROW && !last_row) row_idx_q <= row_idx_q + ROW_W'(1);
    end

    // Sticky done flags: reloaded in SET_NUM (a same-cycle done wins), accumulated
    // while waiting, so pulse-style completions are never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifmap_sticky_q <= '0;
            ipsum_sticky_q <= '0;
            opsum_sticky_q <= '0;
        end else if (abort_hit) begin
            ifmap_sticky_q <= '0;
            ipsum_sticky_q <= '0;
            opsum_sticky_q <= '0;
        end else if (state == S_SET_NUM) begin
            ifmap_sticky_q <= bus.ifmap_done_i;
            ipsum_sticky_q <= bus.ipsum_done_i;
            opsum_sticky_q <= bus.opsum_done_i;
        end else if (state == S_WAIT_DONE) begin
            ifmap_sticky_q <= ifmap_sticky_q | bus.ifmap_done_i;
            ipsum_sticky_q <= ipsum_sticky_q | bus.ipsum_done_i;
            opsum_sticky_q <= opsum_sticky_q | bus.opsum_done_i;
        end
    end

    // Completion pulse follows the DONE state; the error flag lives until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == S_DONE) && !bus.abort_i;
            if (start_accept) err_q <= (bus.layer_type_i == LT_ILLEGAL);
        end
    end

    // Request outputs are driven only during SET_NUM, from the latched configuration.
    always_comb begin
        bus.ifmap_need_pop_o  = set_num ? ifmap_mask : '0;
        bus.ipsum_need_pop_o  = set_num ? ipsum_mask : '0;
        bus.opsum_need_push_o = set_num ? opsum_mask : '0;
        bus.ifmap_pop_num_o   = '0;
        bus.ipsum_pop_num_o   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (set_num && ifmap_mask[k]) bus.ifmap_pop_num_o[k*CNT_W +: CNT_W] = ifmap_cfg_q;
            if (set_num && ipsum_mask[k]) bus.ipsum_pop_num_o[k*CNT_W +: CNT_W] = ipsum_cfg_q;
        end
    end

    assign bus.row_idx_o = row_idx_q;
    assign bus.busy_o    = (state != S_IDLE);
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_l2c_normal_loop_ctrl.sv
// Bench for l2c_normal_loop_ctrl: directed runs push their expected output events
// (request cycles and done pulses, with the cycle they must appear on) into a queue;
// an independent monitor pops and compares whenever the DUT shows an output.
module tb_l2c_normal_loop_ctrl;
    localparam int NUM_CH = 32;
    localparam int CNT_W  = 16;
    localparam int ROW_W  = 16;
    localparam int VW     = NUM_CH * CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2c_normal_loop_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ROW_W(ROW_W)) bus ();

    l2c_normal_loop_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {EV_REQ, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        int                cyc;
        logic [ROW_W-1:0]  row;
        logic [NUM_CH-1:0] ifm;
        logic [NUM_CH-1:0] ips;
        logic [NUM_CH-1:0] ops;
        logic [VW-1:0]     ifn;
        logic [VW-1:0]     ipn;
        logic              err;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  s0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_vec(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pop_vec(logic [NUM_CH-1:0] en, logic [CNT_W-1:0] cfg);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) if (en[k]) v[k*CNT_W +: CNT_W] = cfg;
        return v;
    endfunction

    task automatic exp_req(int rel, int row, logic [1:0] lt, logic [NUM_CH-1:0] en,
                           logic [CNT_W-1:0] ic, logic [CNT_W-1:0] pc);
        ev_t e;
        e.kind = EV_REQ;
        e.cyc  = s0 + rel;
        e.row  = ROW_W'(row);
        e.ifm  = en;
        e.ops  = en;
        e.ips  = (lt == 2'd1) ? '0 : en;
        e.ifn  = pop_vec(en, ic);
        e.ipn  = (lt == 2'd1) ? '0 : pop_vec(en, pc);
        e.err  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(int rel, int row, logic err);
        ev_t e;
        e.kind = EV_DONE;
        e.cyc  = s0 + rel;
        e.row  = ROW_W'(row);
        e.ifm  = '0;
        e.ips  = '0;
        e.ops  = '0;
        e.ifn  = '0;
        e.ipn  = '0;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Raise start on a falling edge; relative cycle 0 is the cycle it is sampled in.
    task automatic begin_start(logic [1:0] lt, logic [ROW_W-1:0] rows, logic [CNT_W-1:0] ic,
                               logic [CNT_W-1:0] pc, logic [NUM_CH-1:0] en);
        @(negedge clk);
        s0                  = cyc;
        bus.start_i         = 1'b1;
        bus.layer_type_i    = lt;
        bus.num_rows_i      = rows;
        bus.ifmap_pop_cfg_i = ic;
        bus.ipsum_pop_cfg_i = pc;
        bus.ch_en_i         = en;
    endtask

    task automatic at_rel(int r);
        while (cyc - s0 < r) @(negedge clk);
    endtask

    // Drop start and scramble the config inputs, which must no longer matter.
    task automatic end_start();
        at_rel(1);
        bus.start_i         = 1'b0;
        bus.layer_type_i    = ~bus.layer_type_i;
        bus.num_rows_i      = ~bus.num_rows_i;
        bus.ifmap_pop_cfg_i = ~bus.ifmap_pop_cfg_i;
        bus.ipsum_pop_cfg_i = ~bus.ipsum_pop_cfg_i;
        bus.ch_en_i         = ~bus.ch_en_i;
    endtask

    task automatic set_done(logic [NUM_CH-1:0] ifm, logic [NUM_CH-1:0] ips, logic [NUM_CH-1:0] ops);
        bus.ifmap_done_i = ifm;
        bus.ipsum_done_i = ips;
        bus.opsum_done_i = ops;
    endtask

    task automatic check_idle_outputs(string tag);
        check_int({tag, "_busy"}, int'(bus.busy_o), 0);
        check_int({tag, "_done"}, int'(bus.done_o), 0);
        check_int({tag, "_row_idx"}, int'(bus.row_idx_o), 0);
        check_vec({tag, "_ifmap_need_pop"}, VW'(bus.ifmap_need_pop_o), '0);
        check_vec({tag, "_ifmap_pop_num"}, bus.ifmap_pop_num_o, '0);
    endtask

    // Monitor: every cycle that shows a request or a done pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && ((|bus.ifmap_need_pop_o) || (|bus.ipsum_need_pop_o) ||
                      (|bus.opsum_need_push_o) || (|bus.ifmap_pop_num_o) ||
                      (|bus.ipsum_pop_num_o) || bus.done_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: cycle %0d done_o=%0b ifmap_need_pop=%0h",
                         cyc, bus.done_o, bus.ifmap_need_pop_o);
            end else begin
                e = exp_q.pop_front();
                check_int("event_kind_is_done", int'(bus.done_o), (e.kind == EV_DONE) ? 1 : 0);
                check_int("event_cycle", cyc, e.cyc);
                check_int("event_row_idx", int'(bus.row_idx_o), int'(e.row));
                check_int("event_err", int'(bus.err_o), int'(e.err));
                check_vec("ifmap_need_pop", VW'(bus.ifmap_need_pop_o), VW'(e.ifm));
                check_vec("ipsum_need_pop", VW'(bus.ipsum_need_pop_o), VW'(e.ips));
                check_vec("opsum_need_push", VW'(bus.opsum_need_push_o), VW'(e.ops));
                check_vec("ifmap_pop_num", bus.ifmap_pop_num_o, e.ifn);
                check_vec("ipsum_pop_num", bus.ipsum_pop_num_o, e.ipn);
                if (e.kind == EV_REQ) check_int("req_busy", int'(bus.busy_o), 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, %0d events pending", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        bus.start_i         = 1'b0;
        bus.abort_i         = 1'b0;
        bus.layer_type_i    = '0;
        bus.num_rows_i      = '0;
        bus.ifmap_pop_cfg_i = '0;
        bus.ipsum_pop_cfg_i = '0;
        bus.ch_en_i         = '0;
        set_done('0, '0, '0);

        // Reset values, during and just after reset.
        #12;
        check_idle_outputs("reset");
        check_int("reset_err", int'(bus.err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Pointwise, 2 rows, channels 0..3, done pulses 5 cycles after each SET_NUM.
        begin_start(2'd0, 16'd2, 16'd4, 16'd2, 32'h0000_000F);
        exp_req(1, 0, 2'd0, 32'h0000_000F, 16'd4, 16'd2);
        exp_req(8, 1, 2'd0, 32'h0000_000F, 16'd4, 16'd2);
        exp_done(16, 1, 1'b0);
        end_start();
        at_rel(4);  check_int("pw_busy_wait", int'(bus.busy_o), 1);
        at_rel(6);  set_done(32'hF, 32'hF, 32'hF);
        at_rel(7);  set_done('0, '0, '0);
        at_rel(13); set_done(32'hF, 32'hF, 32'hF);
        at_rel(14); set_done('0, '0, '0);
        at_rel(18);
        check_int("pw_idle_busy", int'(bus.busy_o), 0);
        check_int("pw_row_idx_hold", int'(bus.row_idx_o), 1);

        // Depthwise, all channels, ipsum never reports; ifmap and opsum at different times.
        begin_start(2'd1, 16'd1, 16'd3, 16'd7, '1);
        exp_req(1, 0, 2'd1, '1, 16'd3, 16'd7);
        exp_done(8, 0, 1'b0);
        end_start();
        at_rel(3);  set_done('1, '0, '0);
        at_rel(4);  set_done('0, '0, '0);
        at_rel(5);  check_int("dw_waits_for_opsum", int'(bus.busy_o), 1);
                    set_done('0, '0, '1);
        at_rel(6);  set_done('0, '0, '0);
        at_rel(10);

        // Zero rows: straight to done, no requests.
        begin_start(2'd2, 16'd0, 16'd9, 16'd9, 32'h0000_000F);
        exp_done(2, 0, 1'b0);
        end_start();
        at_rel(5);

        // Illegal layer type: done pulse with err set, err stays while idle.
        begin_start(2'd3, 16'd5, 16'd1, 16'd1, 32'h0000_000F);
        exp_done(2, 0, 1'b1);
        end_start();
        at_rel(5);
        check_int("illegal_err_sticky", int'(bus.err_o), 1);

        // Same-cycle done during SET_NUM for all channels; also clears err.
        begin_start(2'd2, 16'd1, 16'd1, 16'd1, '1);
        exp_req(1, 0, 2'd2, '1, 16'd1, 16'd1);
        exp_done(5, 0, 1'b0);
        end_start();
        set_done('1, '1, '1);
        at_rel(2);  set_done('0, '0, '0);
        at_rel(7);

        // Staggered ifmap completions; row finishes only after channel 3.
        begin_start(2'd0, 16'd1, 16'd5, 16'd6, 32'h0000_000F);
        exp_req(1, 0, 2'd0, 32'h0000_000F, 16'd5, 16'd6);
        exp_done(11, 0, 1'b0);
        end_start();
        at_rel(2);  set_done(32'h1, 32'hF, 32'hF);
        at_rel(3);  set_done('0, '0, '0);
        for (int k = 1; k < 4; k++) begin
            at_rel(2 + 2*k);
            if (k == 3) check_int("stagger_busy_before_last", int'(bus.busy_o), 1);
            bus.ifmap_done_i = NUM_CH'(1) << k;
            at_rel(3 + 2*k);
            bus.ifmap_done_i = '0;
        end
        at_rel(14);

        // Abort in row 1 of 3; a start while busy (illegal type) must be ignored.
        begin_start(2'd0, 16'd3, 16'd2, 16'd2, 32'h0000_0003);
        exp_req(1, 0, 2'd0, 32'h0000_0003, 16'd2, 16'd2);
        exp_req(4, 1, 2'd0, 32'h0000_0003, 16'd2, 16'd2);
        end_start();
        at_rel(2);
        set_done(32'h3, 32'h3, 32'h3);
        bus.start_i      = 1'b1;
        bus.layer_type_i = 2'd3;
        bus.num_rows_i   = '0;
        at_rel(3);
        set_done('0, '0, '0);
        bus.start_i = 1'b0;
        at_rel(6);  bus.abort_i = 1'b1;
        at_rel(7);  bus.abort_i = 1'b0;
        check_int("abort_busy", int'(bus.busy_o), 0);
        check_int("abort_row_idx", int'(bus.row_idx_o), 0);
        check_int("abort_no_done", int'(bus.done_o), 0);
        check_int("busy_start_no_err", int'(bus.err_o), 0);
        at_rel(14);

        // Asynchronous reset in the middle of row 1.
        begin_start(2'd0, 16'd2, 16'd4, 16'd2, 32'h0000_000F);
        exp_req(1, 0, 2'd0, 32'h0000_000F, 16'd4, 16'd2);
        exp_req(4, 1, 2'd0, 32'h0000_000F, 16'd4, 16'd2);
        end_start();
        at_rel(2);  set_done(32'hF, 32'hF, 32'hF);
        at_rel(3);  set_done('0, '0, '0);
        at_rel(5);
        check_int("pre_reset_row_idx", int'(bus.row_idx_o), 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_async_reset");

        // Every expected event must have been consumed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check_int("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
